// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and defaults for the pipeline hazard controller.
//                Optional feature macro used by the block: HAZARD_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Controller states; encodings are visible on state_o for debug.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } hazard_state_e;

    // Parameter defaults.
    localparam int MDU_TIMEOUT_DEFAULT  = 64;
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // Counter widths sized for the legal parameter ranges (2..255, 1..15).
    localparam int MDU_CNT_W   = 8;
    localparam int FLUSH_CNT_W = 4;

    // Bundle of every pipeline control output.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_bubble;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_bubble;
        logic mdu_timeout;
    } hazard_ctl_t;

    // Front-end freeze common to every wait: PC, IF/ID and ID/EX held.
    function automatic hazard_ctl_t front_stall();
        hazard_ctl_t c;
        c             = '0;
        c.pc_stall    = 1'b1;
        c.if_id_stall = 1'b1;
        c.id_ex_stall = 1'b1;
        return c;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Three free-running 64-bit event counters for the hazard
//                controller (stall cycles, bubbles, redirects). Instantiated
//                only when HAZARD_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        bubble_inc,
    input  logic        flush_inc,
    output logic [63:0] perf_stall_cycles,
    output logic [63:0] perf_bubble_cnt,
    output logic [63:0] perf_flush_cnt
);

    logic [63:0] stall_cnt_q,  stall_cnt_d;
    logic [63:0] bubble_cnt_q, bubble_cnt_d;
    logic [63:0] flush_cnt_q,  flush_cnt_d;

    // Next counts: each counter wraps naturally at 2^64.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall_inc)  stall_cnt_d  = stall_cnt_q  + 64'd1;
        if (bubble_inc) bubble_cnt_d = bubble_cnt_q + 64'd1;
        if (flush_inc)  flush_cnt_d  = flush_cnt_q  + 64'd1;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_bubble_cnt   = bubble_cnt_q;
    assign perf_flush_cnt    = flush_cnt_q;

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Generates stall/bubble/flush for
//                the IF/ID, ID/EX and EX/MEM registers from load-use hazards,
//                memory and MDU back-pressure and EX control transfers.
//                Optional macro HAZARD_PERF_CNT_EN adds 64-bit perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT  = MDU_TIMEOUT_DEFAULT,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    // ID side
    input  logic       id_valid,
    input  logic [4:0] id_rs1addr,
    input  logic [4:0] id_rs2addr,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    // EX side
    input  logic [4:0] ex_rwaddr,
    input  logic       ex_writeRD,
    input  logic       ex_memoryReadWen,
    input  logic       ex_redirect,
    input  logic       ex_mdu_start,
    input  logic       ex_mdu_done,
    // Memory
    input  logic       mem_busy,
    // Controls
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_bubble,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       ex_mem_bubble,
    output logic       mdu_timeout,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [63:0] perf_stall_cycles,
    output logic [63:0] perf_bubble_cnt,
    output logic [63:0] perf_flush_cnt
`endif
);

    // Last legal MDU cycle index and the number of extra IF/ID flush cycles.
    localparam logic [MDU_CNT_W-1:0]   MDU_LAST   = MDU_CNT_W'(MDU_TIMEOUT - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam bit                     FLUSH_MULTI = (FLUSH_CYCLES > 1);

    hazard_state_e          state_q, state_d;
    logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_ctl_t ctl_raw;
    hazard_ctl_t ctl_out;
    logic        load_use;
    logic        redirect_taken;

    // Load in EX writes a register that the instruction in ID reads.
    always_comb begin
        load_use = id_valid & ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) &
                   ((id_use_rs1 & (id_rs1addr == ex_rwaddr)) |
                    (id_use_rs2 & (id_rs2addr == ex_rwaddr)));
    end

    // Next-state, counter and raw control decode.
    // The MDU counter holds the index of the current cycle of an operation,
    // the issue cycle being index 0, so the issue cycle loads it with 1.
    always_comb begin
        state_d        = state_q;
        mdu_cnt_d      = mdu_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        ctl_raw        = '0;
        redirect_taken = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    redirect_taken      = 1'b1;
                    ctl_raw.if_id_flush = 1'b1;
                    ctl_raw.id_ex_flush = 1'b1;
                    if (FLUSH_MULTI) begin
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end
                end else if (mem_busy) begin
                    ctl_raw              = front_stall();
                    ctl_raw.ex_mem_stall = 1'b1;
                    state_d              = ST_MEM_WAIT;
                end else if (ex_mdu_start) begin
                    // A same-cycle done means a zero-latency result: no stall.
                    if (!ex_mdu_done) begin
                        ctl_raw               = front_stall();
                        ctl_raw.ex_mem_bubble = 1'b1;
                        mdu_cnt_d             = MDU_CNT_W'(1);
                        state_d               = ST_MDU_WAIT;
                    end else begin
                        mdu_cnt_d = '0;
                    end
                end else if (load_use) begin
                    ctl_raw.pc_stall     = 1'b1;
                    ctl_raw.if_id_stall  = 1'b1;
                    ctl_raw.id_ex_bubble = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // A redirect here is left alone; EX is frozen and re-presents it.
                if (mem_busy) begin
                    ctl_raw              = front_stall();
                    ctl_raw.ex_mem_stall = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_MDU_WAIT: begin
                if (ex_mdu_done) begin
                    mdu_cnt_d = '0;
                    state_d   = ST_RUN;
                end else if (mdu_cnt_q == MDU_LAST) begin
                    // Forced release of a hung MDU.
                    ctl_raw.mdu_timeout = 1'b1;
                    mdu_cnt_d           = '0;
                    state_d             = ST_RUN;
                end else begin
                    ctl_raw = front_stall();
                    if (mem_busy) ctl_raw.ex_mem_stall  = 1'b1;
                    else          ctl_raw.ex_mem_bubble = 1'b1;
                    mdu_cnt_d = mdu_cnt_q + MDU_CNT_W'(1);
                end
            end

            ST_FLUSH: begin
                ctl_raw.if_id_flush = 1'b1;
                flush_cnt_d         = flush_cnt_q - FLUSH_CNT_W'(1);
                if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Final outputs: a flush overrides stall/bubble on the same register,
    // and everything is forced low while reset is held.
    always_comb begin
        ctl_out              = ctl_raw;
        ctl_out.if_id_stall  = ctl_raw.if_id_stall  & ~ctl_raw.if_id_flush;
        ctl_out.id_ex_stall  = ctl_raw.id_ex_stall  & ~ctl_raw.id_ex_flush;
        ctl_out.id_ex_bubble = ctl_raw.id_ex_bubble & ~ctl_raw.id_ex_flush;
        if (rst) begin
            ctl_out = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_stall      = ctl_out.pc_stall;
    assign if_id_stall   = ctl_out.if_id_stall;
    assign if_id_flush   = ctl_out.if_id_flush;
    assign id_ex_stall   = ctl_out.id_ex_stall;
    assign id_ex_bubble  = ctl_out.id_ex_bubble;
    assign id_ex_flush   = ctl_out.id_ex_flush;
    assign ex_mem_stall  = ctl_out.ex_mem_stall;
    assign ex_mem_bubble = ctl_out.ex_mem_bubble;
    assign mdu_timeout   = ctl_out.mdu_timeout;
    assign state_o       = rst ? ST_RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk               (clk),
        .rst               (rst),
        .stall_inc         (ctl_out.pc_stall),
        .bubble_inc        (ctl_out.id_ex_bubble),
        .flush_inc         (redirect_taken & ~rst),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubble_cnt   (perf_bubble_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
    );
`else
    // Redirect strobe only feeds the optional counters.
    logic unused_redirect;
    assign unused_redirect = redirect_taken;
`endif

endmodule : hazard_ctrl
`default_nettype wire
